apb_mem_arb: RTL and testbench
==============================

APB_MEM_ARB -- requirements
Module: apb_mem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default $clog2(`MEM_SIZE), word address width.
REQ-002 SHALL have parameter DATA_W, default `MEM_WIDTH*`MEM_DEPTH, word data width.
REQ-003 SHALL have parameter BE_W, default `MEM_DEPTH, byte-lane enable width.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have, for each requester N in {0,1}: reqN_valid  input  1  request pending.
REQ-007 SHALL have reqN_write  input  1  1 = write, 0 = read.
REQ-008 SHALL have reqN_addr  input  ADDR_W  word address.
REQ-009 SHALL have reqN_be  input  BE_W  byte-lane enables.
REQ-010 SHALL have reqN_wdata  input  DATA_W  write data.
REQ-011 SHALL have reqN_ready  output  1  request accepted this cycle.
REQ-012 SHALL have rspN_valid  output  1  one-cycle completion pulse.
REQ-013 SHALL have rspN_rdata  output  DATA_W  read data, valid with rspN_valid.
REQ-014 SHALL have memory-side ports mem_wr, mem_rd (output 1), mem_address (output ADDR_W), mem_be (output BE_W), mem_data_in (output DATA_W) and mem_data_out (input DATA_W).

Function
REQ-015 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE, with unconditional ACCESS->RESP and RESP->IDLE transitions.
REQ-016 SHALL, in IDLE only, assert reqN_ready combinationally for the single winning port with reqN_valid=1; handshake = valid&&ready.
REQ-017 SHALL, when exactly one valid is high in IDLE, grant that port.
REQ-018 SHALL, when both valids are high in IDLE, grant the port not granted most recently (round-robin pointer); the pointer updates only on a grant.
REQ-019 SHALL latch write, addr, be, wdata and grant id in registers on the handshake edge and move to ACCESS.
REQ-020 SHALL, in ACCESS, drive mem_address, mem_be and mem_data_in from the latched request, with mem_wr=latched write and mem_rd=!latched write.
REQ-021 SHALL register mem_data_out at the end of ACCESS for reads, and register zero for writes.
REQ-022 SHALL, in RESP, pulse rspN_valid for the latched port only, with rspN_rdata = registered data; both are otherwise 0.
REQ-023 SHALL hold mem_wr, mem_rd, mem_address, mem_be and mem_data_in at 0 outside ACCESS.
REQ-024 SHALL give fixed latency: handshake edge +1 cycle is ACCESS and +2 cycles is RESP; peak throughput is one transaction per 3 cycles.
REQ-025 SHALL keep reqN_ready=0 in ACCESS and RESP; requesters hold valid and fields stable until ready.
REQ-026 SHALL pass reqN_be to the memory unmodified; be=0 writes commit nothing but still complete with a response.
REQ-027 SHALL accept addresses from 0 to 2^ADDR_W-1 with no wrap or range checking.

Reset
REQ-028 SHALL, on rst=1 at a posedge, go to IDLE, set the round-robin pointer so port 0 wins the first tie, and clear the latched request and read-data registers.
REQ-029 SHALL drive every output to 0 during and after reset until the first grant.
REQ-030 SHALL handle reset asserted in ACCESS as follows: a write still commits at that edge because the memory is not reset, and no response is issued.

Structure
REQ-031 SHALL take the FSM state enum (IDLE/ACCESS/RESP) from shared package apb_mem_pkg; width defaults derive from apb_arch.svh macros.
REQ-032 SHALL contain one natural sub-module, apb_rr_arb2: a 2-way round-robin arbiter with grant and pointer-update logic.

Verification
REQ-033 Single write: req0 write addr=5 be=4'hF wdata=32'hDEADBEEF -> ready0 at cycle 0, mem_wr=1 at cycle 1, rsp0_valid at cycle 2 with rdata=0, ram word 5 = DEADBEEF.
REQ-034 Read-back: req1 read addr=5 after REQ-033 -> mem_rd=1 for one cycle, rsp1_valid 2 cycles after ready1 with rdata=32'hDEADBEEF.
REQ-035 Contention: both valid from reset, continuously -> grants alternate 0,1,0,1, each grant 3 cycles apart, with no port served twice in a row.
REQ-036 Byte enables: write 32'h11223344 be=4'b0101 to a word previously holding 32'hAABBCCDD, then read -> 32'hAA22CC44.
REQ-037 Reset mid-ACCESS: assert rst during a write ACCESS -> no rsp pulse, FSM in IDLE the next cycle, all outputs 0, write committed.
REQ-038 Idle behaviour: no valid for 20 cycles -> mem_wr, mem_rd, ready and rsp signals all stay 0.

Source files
------------

// File: rtl/apb_mem_pkg.sv
`default_nettype none
// apb_mem_pkg: memory architecture macros and the shared arbiter FSM state type.
`ifndef MEM_SIZE
`define MEM_SIZE 256
`endif
`ifndef MEM_WIDTH
`define MEM_WIDTH 8
`endif
`ifndef MEM_DEPTH
`define MEM_DEPTH 4
`endif

package apb_mem_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;
endpackage
`default_nettype wire

// File: rtl/apb_rr_arb2.sv
`default_nettype none
// apb_rr_arb2: two-way round-robin arbiter; the tie pointer moves only when a grant is issued.
module apb_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o,
   output logic       gnt_id_o
);

   // prio_q names the port that wins the next tie
   logic prio_q;
   logic prio_d;

   always_comb begin
      gnt_o    = 2'b00;
      gnt_id_o = 1'b0;
      if (en_i) begin
         case (req_i)
            2'b01: begin
               gnt_o    = 2'b01;
               gnt_id_o = 1'b0;
            end
            2'b10: begin
               gnt_o    = 2'b10;
               gnt_id_o = 1'b1;
            end
            2'b11: begin
               gnt_o    = prio_q ? 2'b10 : 2'b01;
               gnt_id_o = prio_q;
            end
            default: begin
               gnt_o    = 2'b00;
               gnt_id_o = 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      prio_d = prio_q;
      if (|gnt_o) begin
         prio_d = ~gnt_id_o;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/apb_mem_arb.sv
`default_nettype none
// apb_mem_arb: arbitrates two requesters onto one single-port memory with a fixed
// IDLE -> ACCESS -> RESP sequence per transaction.
module apb_mem_arb
   import apb_mem_pkg::*;
#(
   parameter int ADDR_W = $clog2(`MEM_SIZE),
   parameter int DATA_W = `MEM_WIDTH * `MEM_DEPTH,
   parameter int BE_W   = `MEM_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic              req0_write,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [BE_W-1:0]   req0_be,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   input  logic              req1_valid,
   input  logic              req1_write,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [BE_W-1:0]   req1_be,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic              mem_wr,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_be,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out
);

   state_t            state_q, state_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BE_W-1:0]   be_q, be_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              id_q, id_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic [1:0] gnt;
   logic       gnt_id;
   logic       arb_en;
   logic       in_access;
   logic       in_resp;

   // Grants are suppressed while rst is high so no handshake can start during reset
   assign arb_en = (state_q == IDLE) && !rst;

   apb_rr_arb2 u_arb (
      .clk      (clk),
      .rst      (rst),
      .en_i     (arb_en),
      .req_i    ({req1_valid, req0_valid}),
      .gnt_o    (gnt),
      .gnt_id_o (gnt_id)
   );

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      id_d    = id_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (|gnt) begin
               state_d = ACCESS;
               id_d    = gnt_id;
               wr_d    = gnt_id ? req1_write : req0_write;
               addr_d  = gnt_id ? req1_addr  : req0_addr;
               be_d    = gnt_id ? req1_be    : req0_be;
               wdata_d = gnt_id ? req1_wdata : req0_wdata;
            end
         end
         ACCESS: begin
            state_d = RESP;
            rdata_d = wr_q ? '0 : mem_data_out;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         id_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         id_q    <= id_d;
         rdata_q <= rdata_d;
      end
   end

   // Memory strobes stay live through a reset edge in ACCESS: the memory itself is not reset
   assign in_access   = (state_q == ACCESS);
   assign in_resp     = (state_q == RESP) && !rst;

   assign req0_ready  = gnt[0];
   assign req1_ready  = gnt[1];

   assign mem_wr      = in_access &&  wr_q;
   assign mem_rd      = in_access && !wr_q;
   assign mem_address = in_access ? addr_q  : '0;
   assign mem_be      = in_access ? be_q    : '0;
   assign mem_data_in = in_access ? wdata_q : '0;

   assign rsp0_valid  = in_resp && !id_q;
   assign rsp1_valid  = in_resp &&  id_q;
   assign rsp0_rdata  = rsp0_valid ? rdata_q : '0;
   assign rsp1_rdata  = rsp1_valid ? rdata_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_apb_mem_arb.sv
`default_nettype none
// tb_apb_mem_arb: directed transaction table plus contention, idle and reset-in-ACCESS sequences.
module tb_apb_mem_arb;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int BW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0_valid, req0_write, req0_ready, rsp0_valid;
   logic [AW-1:0] req0_addr;
   logic [BW-1:0] req0_be;
   logic [DW-1:0] req0_wdata, rsp0_rdata;
   logic          req1_valid, req1_write, req1_ready, rsp1_valid;
   logic [AW-1:0] req1_addr;
   logic [BW-1:0] req1_be;
   logic [DW-1:0] req1_wdata, rsp1_rdata;
   logic          mem_wr, mem_rd;
   logic [AW-1:0] mem_address;
   logic [BW-1:0] mem_be;
   logic [DW-1:0] mem_data_in, mem_data_out;

   logic [DW-1:0] ram [0:(1<<AW)-1];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   apb_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
      .req0_be(req0_be), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
      .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
      .req1_be(req1_be), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
      .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_address(mem_address),
      .mem_be(mem_be), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
   );

   // Byte-lane memory model with asynchronous read
   always @(posedge clk) begin
      if (mem_wr) begin
         for (int b = 0; b < BW; b++) begin
            if (mem_be[b]) ram[mem_address][8*b +: 8] <= mem_data_in[8*b +: 8];
         end
      end
   end
   assign mem_data_out = ram[mem_address];

   typedef struct {
      logic          port;
      logic          wr;
      logic [AW-1:0] addr;
      logic [BW-1:0] be;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return {32'(req0_ready), 32'(req1_ready)} ^ 64'(rsp0_valid) ^ 64'(rsp1_valid)
             ^ 64'(mem_wr) ^ 64'(mem_rd) ^ 64'(mem_address) ^ 64'(mem_be)
             ^ 64'(mem_data_in) ^ 64'(rsp0_rdata) ^ 64'(rsp1_rdata)
             | {63'd0, |{req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_wr, mem_rd,
                         mem_address, mem_be, mem_data_in, rsp0_rdata, rsp1_rdata}};
   endfunction

   task automatic clear_reqs();
      req0_valid = 0; req0_write = 0; req0_addr = '0; req0_be = '0; req0_wdata = '0;
      req1_valid = 0; req1_write = 0; req1_addr = '0; req1_be = '0; req1_wdata = '0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      if (v.port) begin
         req1_valid = 1; req1_write = v.wr; req1_addr = v.addr; req1_be = v.be; req1_wdata = v.wdata;
      end else begin
         req0_valid = 1; req0_write = v.wr; req0_addr = v.addr; req0_be = v.be; req0_wdata = v.wdata;
      end
      @(negedge clk);
      chk($sformatf("v%0d_ready", idx), {req1_ready, req0_ready}, v.port ? 2'b10 : 2'b01);
      @(posedge clk); #1;
      clear_reqs();
      @(negedge clk);
      chk($sformatf("v%0d_mem_ctl", idx), {mem_wr, mem_rd}, {v.wr, !v.wr});
      chk($sformatf("v%0d_mem_addr", idx), mem_address, v.addr);
      chk($sformatf("v%0d_mem_be", idx), mem_be, v.be);
      chk($sformatf("v%0d_mem_din", idx), mem_data_in, v.wdata);
      chk($sformatf("v%0d_access_hs", idx), {rsp1_valid, rsp0_valid, req1_ready, req0_ready}, 4'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("v%0d_rsp_valid", idx), {rsp1_valid, rsp0_valid}, v.port ? 2'b10 : 2'b01);
      chk($sformatf("v%0d_rsp_rdata", idx), v.port ? rsp1_rdata : rsp0_rdata, v.rdata);
      chk($sformatf("v%0d_rsp_other", idx), v.port ? rsp0_rdata : rsp1_rdata, 32'h0);
      chk($sformatf("v%0d_resp_mem", idx), {mem_wr, mem_rd}, 2'b00);
      @(posedge clk); #1;
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
      vecs[0]  = '{1'b0, 1'b1, 8'd5,   4'hF, 32'hDEADBEEF, 32'h0};
      vecs[1]  = '{1'b1, 1'b0, 8'd5,   4'hF, 32'h0,        32'hDEADBEEF};
      vecs[2]  = '{1'b0, 1'b1, 8'd9,   4'hF, 32'hAABBCCDD, 32'h0};
      vecs[3]  = '{1'b1, 1'b1, 8'd9,   4'b0101, 32'h11223344, 32'h0};
      vecs[4]  = '{1'b0, 1'b0, 8'd9,   4'hF, 32'h0,        32'hAA22CC44};
      vecs[5]  = '{1'b1, 1'b1, 8'd255, 4'hF, 32'h12345678, 32'h0};
      vecs[6]  = '{1'b0, 1'b0, 8'd255, 4'hF, 32'h0,        32'h12345678};
      vecs[7]  = '{1'b0, 1'b1, 8'd0,   4'h0, 32'hFFFFFFFF, 32'h0};
      vecs[8]  = '{1'b1, 1'b0, 8'd0,   4'hF, 32'h0,        32'h0};
      vecs[9]  = '{1'b0, 1'b0, 8'd5,   4'h3, 32'h5A5A5A5A, 32'hDEADBEEF};
      vecs[10] = '{1'b1, 1'b1, 8'd128, 4'b1000, 32'h9F000000, 32'h0};

      clear_reqs();
      rst = 1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("reset_outputs", all_outs(), 64'h0);
      req0_valid = 1; req1_valid = 1;
      @(negedge clk);
      chk("reset_ready_gated", {req1_ready, req0_ready, rsp1_valid, rsp0_valid}, 4'b0);

      // Continuous contention straight out of reset
      @(posedge clk); #1;
      rst = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk($sformatf("cont_c%0d", c), {rsp1_valid, rsp0_valid, req1_ready, req0_ready},
             {(c % 6) == 5, (c % 6) == 2, (c % 6) == 3, (c % 6) == 0});
         @(posedge clk); #1;
      end
      clear_reqs();
      rst = 1;
      @(posedge clk); #1;
      rst = 0;

      for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);
      chk("ram5_write", ram[5], 32'hDEADBEEF);
      chk("ram0_be0", ram[0], 32'h0);
      chk("ram128_lane3", ram[128], 32'h9F000000);

      // Idle for 20 cycles
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk($sformatf("idle_c%0d", c), {mem_wr, mem_rd, req1_ready, req0_ready, rsp1_valid, rsp0_valid}, 6'b0);
         @(posedge clk); #1;
      end

      // Reset asserted while a write is in ACCESS
      req0_valid = 1; req0_write = 1; req0_addr = 8'd20; req0_be = 4'hF; req0_wdata = 32'hCAFEF00D;
      @(negedge clk);
      chk("rstacc_ready", {req1_ready, req0_ready}, 2'b01);
      @(posedge clk); #1;
      clear_reqs();
      rst = 1;
      @(negedge clk);
      chk("rstacc_wr", mem_wr, 1'b1);
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      chk("rstacc_outputs", all_outs(), 64'h0);
      chk("rstacc_committed", ram[20], 32'hCAFEF00D);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rstacc_no_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
      @(posedge clk); #1;
      run_vec(11, '{1'b1, 1'b0, 8'd20, 4'hF, 32'h0, 32'hCAFEF00D});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
`default_nettype wire
